// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issues one M-extension op at a time to the MDU and returns the selected 32-bit result with its tag.
// Latency: mdu_start 1 cycle after accept; mdu_ack and rsp_valid 1 cycle after mdu_done (cache hit: rsp 1 cycle after accept).
// Backpressure: req_ready low while an op is outstanding; response held until rsp_ready. Optional macro MDU_FUSE_CACHE_EN.
module mdu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             mdu_start,
    output logic             mdu_ack,
    output logic [2:0]       mdu_funct3,
    output logic [31:0]      mdu_a,
    output logic [31:0]      mdu_b,
    input  logic             mdu_busy,
    input  logic             mdu_done,
    input  logic [63:0]      mdu_product,
    input  logic [31:0]      mdu_quotient,
    input  logic [31:0]      mdu_remainder,
    output logic             err_timeout
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_rsp_data;
    logic               r_ack;
    logic               r_err;
    logic               w_accept;
    logic               w_capture;
    logic               w_ack_set;
    logic               w_timeout;
    logic               w_hit;
    logic [31:0]        w_hit_data;

    // Architectural result selection: low product, high product, quotient or remainder.
    function automatic logic [31:0] f_sel(input logic [2:0] f3, input logic [63:0] prod,
                                          input logic [31:0] quo, input logic [31:0] rem);
        logic [31:0] res;
        case (f3)
            3'b000:                 res = prod[31:0];
            3'b001, 3'b010, 3'b011: res = prod[63:32];
            3'b100, 3'b101:         res = quo;
            default:                res = rem;
        endcase
        return res;
    endfunction

    assign req_ready   = (r_state == S_IDLE) && !flush && !mdu_busy && !rst;
    assign rsp_valid   = (r_state == S_RESP) && !flush;
    assign rsp_data    = r_rsp_data;
    assign rsp_tag     = r_tag;
    assign mdu_start   = (r_state == S_ISSUE);
    assign mdu_ack     = r_ack;
    assign mdu_funct3  = r_funct3;
    assign mdu_a       = r_a;
    assign mdu_b       = r_b;
    assign err_timeout = r_err;

`ifdef MDU_FUSE_CACHE_EN
    logic        r_c_vld;
    logic [2:0]  r_c_f3;
    logic [31:0] r_c_a;
    logic [31:0] r_c_b;
    logic [63:0] r_c_prod;
    logic [31:0] r_c_quo;
    logic [31:0] r_c_rem;
    logic        w_pair;

    // Fusable pairs: MUL after any MULH variant; REM/DIV swap with matching signedness.
    always_comb begin
        w_pair = 1'b0;
        if (req_funct3 == 3'b000)
            w_pair = (r_c_f3 != 3'b000) && !r_c_f3[2];
        else if (req_funct3[2])
            w_pair = r_c_f3[2] && (r_c_f3[0] == req_funct3[0]) && (r_c_f3[1] != req_funct3[1]);
    end

    assign w_hit      = r_c_vld && w_pair && (r_c_a == req_rs1) && (r_c_b == req_rs2);
    assign w_hit_data = f_sel(req_funct3, r_c_prod, r_c_quo, r_c_rem);

    // Remember the full MDU result of the last completed op; any flush or timeout forgets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_vld  <= 1'b0;
            r_c_f3   <= 3'b000;
            r_c_a    <= '0;
            r_c_b    <= '0;
            r_c_prod <= '0;
            r_c_quo  <= '0;
            r_c_rem  <= '0;
        end else if (flush || w_timeout) begin
            r_c_vld  <= 1'b0;
        end else if (w_capture) begin
            r_c_vld  <= 1'b1;
            r_c_f3   <= r_funct3;
            r_c_a    <= r_a;
            r_c_b    <= r_b;
            r_c_prod <= mdu_product;
            r_c_quo  <= mdu_quotient;
            r_c_rem  <= mdu_remainder;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // Next-state and handshake decode; done seen in ISSUE is treated exactly like done in WAIT.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_ack_set = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    w_accept = 1'b1;
                    w_next   = w_hit ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (flush) begin
                    if (mdu_done) begin
                        w_ack_set = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_next    = S_DRAIN;
                    end
                end else if (mdu_done) begin
                    w_capture = 1'b1;
                    w_ack_set = 1'b1;
                    w_next    = S_RESP;
                end else if (r_state == S_WAIT && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end else if (r_state == S_ISSUE) begin
                    w_next    = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (mdu_done) begin
                    w_ack_set = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, WAIT cycle counter, registered ack pulse and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
            r_ack   <= w_ack_set;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    // Operands and tag are held from accept until the next accept, covering the whole MDU op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3 <= 3'b000;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
        end else if (w_accept) begin
            r_funct3 <= req_funct3;
            r_a      <= req_rs1;
            r_b      <= req_rs2;
            r_tag    <= req_tag;
        end
    end

    // Response data: MDU result on done, all-ones on timeout, cached result on a fused hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rsp_data <= '0;
        else if (w_capture)
            r_rsp_data <= f_sel(r_funct3, mdu_product, mdu_quotient, mdu_remainder);
        else if (w_timeout)
            r_rsp_data <= 32'hFFFF_FFFF;
        else if (w_accept && w_hit)
            r_rsp_data <= w_hit_data;
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: directed checks of mdu_issue_ctrl with hand-computed results.
// Inputs driven on the falling edge, outputs checked 1ns later.
// The bench plays the MDU: it holds mdu_done until it has seen mdu_ack.
module tb_mdu_issue_ctrl;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             mdu_start;
    logic             mdu_ack;
    logic [2:0]       mdu_funct3;
    logic [31:0]      mdu_a;
    logic [31:0]      mdu_b;
    logic             mdu_busy;
    logic             mdu_done;
    logic [63:0]      mdu_product;
    logic [31:0]      mdu_quotient;
    logic [31:0]      mdu_remainder;
    logic             err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_ack   = 0;

    mdu_issue_ctrl #(.TIMEOUT_CYCLES(64), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .mdu_start(mdu_start), .mdu_ack(mdu_ack), .mdu_funct3(mdu_funct3),
        .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .mdu_product(mdu_product), .mdu_quotient(mdu_quotient), .mdu_remainder(mdu_remainder),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Pulse counters for start and ack; both are pure state decodes, stable at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            n_start = n_start + (mdu_start ? 1 : 0);
            n_ack   = n_ack + (mdu_ack ? 1 : 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete op: accept, start, done 'dly' cycles after start, 'hold' cycles of rsp backpressure.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tg, input logic [63:0] prod, input logic [31:0] quo,
                          input logic [31:0] rem, input int dly, input int hold, input logic [31:0] exp_d);
        int s0;
        int a0;
        #1 s0 = n_start;
        a0 = n_ack;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = tg;
        mdu_product = prod; mdu_quotient = quo; mdu_remainder = rem;
        #1 chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk({nm, "_start"}, 64'(mdu_start), 64'd1);
        chk({nm, "_mdu_a"}, 64'(mdu_a), 64'(a));
        chk({nm, "_mdu_b"}, 64'(mdu_b), 64'(b));
        for (int i = 1; i < dly; i++) begin
            @(negedge clk);
            #1 chk({nm, "_no_rsp"}, 64'(rsp_valid), 64'd0);
        end
        @(negedge clk);
        mdu_done = 1'b1;
        @(negedge clk);
        #1 chk({nm, "_ack"}, 64'(mdu_ack), 64'd1);
        mdu_done = 1'b0;
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, "_data"}, 64'(rsp_data), 64'(exp_d));
        chk({nm, "_tag"}, 64'(rsp_tag), 64'(tg));
        chk({nm, "_a_held"}, 64'(mdu_a), 64'(a));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1 chk({nm, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({nm, "_hold_data"}, 64'(rsp_data), 64'(exp_d));
            chk({nm, "_hold_tag"}, 64'(rsp_tag), 64'(tg));
            chk({nm, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk({nm, "_rsp_done"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_one_start"}, 64'(n_start - s0), 64'd1);
        chk({nm, "_one_ack"}, 64'(n_ack - a0), 64'd1);
    endtask

    initial begin
        int k;
        int s0;
        int a0;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_funct3 = 3'b000; req_rs1 = '0; req_rs2 = '0;
        req_tag = '0; rsp_ready = 1'b0; mdu_busy = 1'b0; mdu_done = 1'b0;
        mdu_product = '0; mdu_quotient = '0; mdu_remainder = '0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_start", 64'(mdu_start), 64'd0);
        chk("rst_ack", 64'(mdu_ack), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul",   3'b000, 32'd7, 32'd6, 5'h15, 64'd42, 32'd0, 32'd0, 3, 0, 32'd42);
        run_op("div",   3'b100, 32'd100, 32'd7, 5'h03, 64'd0, 32'd14, 32'd2, 2, 0, 32'd14);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'd2, 5'h0A, 64'h1_FFFF_FFFE, 32'd0, 32'd0, 1, 0, 32'd1);
        run_op("rem",   3'b110, 32'd100, 32'd7, 5'h1F, 64'd0, 32'd14, 32'd2, 4, 0, 32'd2);
        run_op("bp",    3'b101, 32'd50, 32'd5, 5'h11, 64'd0, 32'd10, 32'd0, 2, 5, 32'd10);

        // Flush two cycles after start: MDU result is drained and acked once, no response.
        #1 s0 = n_start;
        a0 = n_ack;
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd3; req_rs2 = 32'd3; req_tag = 5'h02;
        mdu_product = 64'd9;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        #1 chk("fl_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk); flush = 1'b0;
        #1 chk("fl_drain_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk); mdu_done = 1'b1;
        @(negedge clk);
        #1 chk("fl_ack", 64'(mdu_ack), 64'd1);
        chk("fl_ack_no_rsp", 64'(rsp_valid), 64'd0);
        mdu_done = 1'b0;
        @(negedge clk);
        #1 chk("fl_one_ack", 64'(n_ack - a0), 64'd1);
        chk("fl_one_start", 64'(n_start - s0), 64'd1);
        chk("fl_idle_ready", 64'(req_ready), 64'd1);
        run_op("after_fl", 3'b000, 32'd4, 32'd5, 5'h04, 64'd20, 32'd0, 32'd0, 2, 0, 32'd20);

        // Timeout: done never comes; response after 64 WAIT cycles (accept c0, ISSUE c1, RESP c66).
        req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd1; req_rs2 = 32'd1; req_tag = 5'h09;
        @(negedge clk); req_valid = 1'b0;
        k = 1;
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            #1 k = c;
            if (c == 65) chk("to_err_early", 64'(err_timeout), 64'd0);
            if (rsp_valid) break;
        end
        chk("to_cycle", 64'(k), 64'd66);
        chk("to_err", 64'(err_timeout), 64'd1);
        chk("to_data", 64'(rsp_data), 64'hFFFF_FFFF);
        chk("to_tag", 64'(rsp_tag), 64'h09);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;

        // MULH then MUL on the same operands.
        #1 s0 = n_start;
        run_op("mulh", 3'b001, 32'd5, 32'd9, 5'h06, 64'h3_0000_002D, 32'd0, 32'd0, 2, 0, 32'd3);
`ifdef MDU_FUSE_CACHE_EN
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd5; req_rs2 = 32'd9; req_tag = 5'h07;
        mdu_product = '0;
        #1 chk("fuse_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk); req_valid = 1'b0;
        #1 chk("fuse_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("fuse_data", 64'(rsp_data), 64'h2D);
        chk("fuse_tag", 64'(rsp_tag), 64'h07);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        #1 chk("fuse_starts", 64'(n_start - s0), 64'd1);
`else
        run_op("mul_nofuse", 3'b000, 32'd5, 32'd9, 5'h07, 64'h3_0000_002D, 32'd0, 32'd0, 2, 0, 32'h2D);
        chk("nofuse_starts", 64'(n_start - s0), 64'd2);
`endif
        chk("err_sticky", 64'(err_timeout), 64'd1);

        // Reset in the middle of an operation returns everything to idle and clears the error.
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd2; req_rs2 = 32'd8; req_tag = 5'h01;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1 chk("mrst_start", 64'(mdu_start), 64'd0);
        chk("mrst_err", 64'(err_timeout), 64'd0);
        chk("mrst_mdu_a", 64'(mdu_a), 64'd0);
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op("post_rst", 3'b010, 32'd2, 32'd8, 5'h1E, 64'h5_0000_0010, 32'd0, 32'd0, 1, 0, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
